// File: rtl/pipe_mem_ctrl.sv
// pipe_mem_ctrl: MEM-stage data-memory handshake FSM plus pipeline stall/flush/branch hazard control
module pipe_mem_ctrl #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memread,
   input  logic        memwrite,
   input  logic        branch,
   input  logic        zero,
   input  logic [31:0] alu_result,
   input  logic        id_ex_memread,
   input  logic [4:0]  id_ex_rt,
   input  logic [4:0]  if_id_rs,
   input  logic [4:0]  if_id_rt,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic        stall_pc,
   output logic        stall_ifid,
   output logic        stall_idex,
   output logic        stall_exmem,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        flush_exmem,
   output logic        pc_src,
   output logic        mem_err,
   output logic [15:0] stall_count
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, state_nx;
   logic [7:0] wait_cnt;
   logic mem_stall, load_use, taken, timeout;
   assign timeout = wait_cnt == 8'(TIMEOUT - 1);
   always_comb begin
      state_nx = state;
      mem_stall = 1'b0;
      load_use = 1'b0;
      taken = 1'b0;
      state_nx = (state == IDLE) ? ((memread | memwrite) ? ACCESS : IDLE) :
                 (state == ACCESS) ? ((mem_ready | timeout) ? DONE : ACCESS) : IDLE;
      mem_stall = ((state == IDLE) & (memread | memwrite)) | (state == ACCESS);
      load_use = id_ex_memread & (id_ex_rt != 5'd0) & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
      taken = branch & zero & ~mem_stall;
      // memory stall beats a taken branch, which beats a load-use bubble
      stall_pc = mem_stall | (load_use & ~taken);
      stall_ifid = mem_stall | (load_use & ~taken);
      stall_idex = mem_stall;
      stall_exmem = mem_stall;
      flush_ifid = taken;
      flush_idex = taken | (load_use & ~mem_stall);
      flush_exmem = taken;
      pc_src = taken;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= 32'd0;
         wait_cnt <= 8'd0;
         mem_err <= 1'b0;
         stall_count <= 16'd0;
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx == ACCESS) begin
            mem_req <= 1'b1;
            mem_we <= memwrite;
            mem_addr <= alu_result;
            wait_cnt <= 8'd0;
         end else if (state == ACCESS) begin
            if (state_nx == DONE) begin
               mem_req <= 1'b0;
               mem_we <= 1'b0;
               mem_addr <= 32'd0;
               mem_err <= mem_err | ~mem_ready;
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
            end
         end
         if (mem_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// tb_pipe_mem_ctrl: directed-vector self-checking bench for pipe_mem_ctrl
module tb_pipe_mem_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic memread = 0, memwrite = 0, branch = 0, zero = 0, id_ex_memread = 0, mem_ready = 0;
   logic [31:0] alu_result = 0;
   logic [4:0] id_ex_rt = 0, if_id_rs = 0, if_id_rt = 0;
   logic mem_req, mem_we, stall_pc, stall_ifid, stall_idex, stall_exmem;
   logic flush_ifid, flush_idex, flush_exmem, pc_src, mem_err;
   logic [31:0] mem_addr;
   logic [15:0] stall_count;
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   pipe_mem_ctrl #(.TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .branch(branch), .zero(zero),
      .alu_result(alu_result), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .mem_ready(mem_ready), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
      .stall_idex(stall_idex), .stall_exmem(stall_exmem), .flush_ifid(flush_ifid),
      .flush_idex(flush_idex), .flush_exmem(flush_exmem), .pc_src(pc_src), .mem_err(mem_err),
      .stall_count(stall_count)
   );
   wire [7:0] ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_exmem, pc_src};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int n;
      step();
      step();
      rst = 0;
      #1;
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_err", 32'(mem_err), 0);
      chk("rst_cnt", 32'(stall_count), 0);
      chk("rst_ctl", 32'(ctl), 0);
      // load at 0x40, ready sampled on the third ACCESS edge
      memread = 1;
      alu_result = 32'h40;
      #1;
      chk("ld_idle_ctl", 32'(ctl), 32'hF0);
      n = 1;
      step();
      chk("ld_req", 32'(mem_req), 1);
      chk("ld_addr", mem_addr, 32'h40);
      chk("ld_we", 32'(mem_we), 0);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) mem_ready = 1;
         #1;
         if (stall_pc) n++;
         step();
      end
      chk("ld_stall_cycles", 32'(n), 4);
      chk("ld_done_req", 32'(mem_req), 0);
      chk("ld_done_addr", mem_addr, 0);
      chk("ld_done_ctl", 32'(ctl), 0);
      chk("ld_cnt", 32'(stall_count), 4);
      branch = 1;
      zero = 1;
      #1;
      chk("done_branch", 32'(ctl), 32'h0F);
      memread = 0;
      mem_ready = 0;
      branch = 0;
      zero = 0;
      step();
      chk("ld_idle_back", 32'(ctl), 0);
      // store that never completes
      memwrite = 1;
      alu_result = 32'h80;
      step();
      memwrite = 0;
      chk("st_we", 32'(mem_we), 1);
      chk("st_addr", mem_addr, 32'h80);
      n = 0;
      while (mem_req && n < 200) begin
         step();
         n++;
      end
      chk("st_timeout_cycles", 32'(n), 64);
      chk("st_err", 32'(mem_err), 1);
      chk("st_done_ctl", 32'(ctl), 0);
      step();
      chk("st_err_sticky", 32'(mem_err), 1);
      step();
      chk("st_err_sticky2", 32'(mem_err), 1);
      // hazard vectors in IDLE
      id_ex_memread = 1;
      id_ex_rt = 5;
      if_id_rs = 3;
      if_id_rt = 5;
      #1;
      chk("lu_rt", 32'(ctl), 32'hC4);
      if_id_rs = 5;
      if_id_rt = 7;
      #1;
      chk("lu_rs", 32'(ctl), 32'hC4);
      id_ex_rt = 0;
      if_id_rs = 0;
      if_id_rt = 0;
      #1;
      chk("lu_r0", 32'(ctl), 0);
      id_ex_rt = 5;
      if_id_rt = 5;
      branch = 1;
      zero = 1;
      #1;
      chk("br_over_lu", 32'(ctl), 32'h0F);
      memread = 1;
      #1;
      chk("mem_over_br", 32'(ctl), 32'hF0);
      memread = 0;
      id_ex_memread = 0;
      zero = 0;
      #1;
      chk("br_not_taken", 32'(ctl), 0);
      branch = 0;
      // reset in second ACCESS cycle
      memread = 1;
      alu_result = 32'h44;
      step();
      step();
      rst = 1;
      step();
      rst = 0;
      memread = 0;
      #1;
      chk("rst_acc_req", 32'(mem_req), 0);
      chk("rst_acc_err", 32'(mem_err), 0);
      chk("rst_acc_ctl", 32'(ctl), 0);
      chk("rst_acc_cnt", 32'(stall_count), 0);
      memread = 1;
      alu_result = 32'h48;
      step();
      chk("restart_req", 32'(mem_req), 1);
      chk("restart_addr", mem_addr, 32'h48);
      mem_ready = 1;
      step();
      memread = 0;
      mem_ready = 0;
      chk("restart_done", 32'(mem_req), 0);
      chk("restart_err", 32'(mem_err), 0);
      chk("restart_cnt", 32'(stall_count), 2);
      step();
      // saturation: repeated timeouts keep stalling
      rst = 1;
      step();
      rst = 0;
      memwrite = 1;
      n = 0;
      while (stall_count != 16'hFFFE && n < 70000) begin
         step();
         n++;
      end
      chk("sat_reach", 32'(stall_count), 32'hFFFE);
      for (int i = 0; i < 70; i++) step();
      chk("sat_hold", 32'(stall_count), 32'hFFFF);
      memwrite = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
